// File: rtl/clock_pkg.sv
// Shared types and constants for the time-setting controller.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    EDIT_H = 3'd1,
    EDIT_M = 3'd2,
    EDIT_S = 3'd3,
    SETUP  = 3'd4,
    PULSE  = 3'd5
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_H    = 2'd1;
  localparam logic [1:0] SEL_M    = 2'd2;
  localparam logic [1:0] SEL_S    = 2'd3;

  localparam logic [3:0] SEC_MAX_T = 4'd5;
  localparam logic [3:0] UNIT_MAX  = 4'd9;
  localparam logic [3:0] HR_MAX_T  = 4'd2;
  localparam logic [3:0] HR_MAX_U  = 4'd3;

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] u;
  } bcd2_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchronizer, stability counter and
// a one-cycle press pulse following each rise of the debounced level.
module btn_debounce #(
  parameter logic [15:0] DEB_CYCLES = 16'd1000
) (
  input  logic CLOCK,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic        sync1, sync2;
  logic        level, level_d;
  logic [15:0] cnt;

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DEB_CYCLES - 16'd1) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/clock_setter.sv
// Button-driven time-setting controller: snapshots the running time,
// edits hours/minutes/seconds, then commits all fields with one set pulse.
module clock_setter
  import clock_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES = 16'd1000,
  parameter logic [3:0]  SET_PULSE  = 4'd4,
  parameter logic [23:0] TIMEOUT    = 24'd500000
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] S0,
  input  logic [3:0] S1,
  input  logic [3:0] M0,
  input  logic [3:0] M1,
  input  logic [3:0] H0,
  input  logic [3:0] H1,
  output logic [3:0] S0_ld,
  output logic [3:0] S1_ld,
  output logic [3:0] M0_ld,
  output logic [3:0] M1_ld,
  output logic [3:0] H0_ld,
  output logic [3:0] H1_ld,
  output logic       set_s,
  output logic       set_m,
  output logic       set_h,
  output logic [1:0] edit_sel
);

  // Anything at or above the field maximum wraps to 00, so corrupt captures recover.
  function automatic bcd2_t inc_field(input bcd2_t v, input logic is_hour);
    bcd2_t r;
    logic  at_max;
    if (is_hour)
      at_max = (v.t > HR_MAX_T) || (v.t == HR_MAX_T && v.u >= HR_MAX_U);
    else
      at_max = (v.t > SEC_MAX_T) || (v.t == SEC_MAX_T && v.u >= UNIT_MAX);
    if (at_max) begin
      r = '0;
    end else if (v.u >= UNIT_MAX) begin
      r.t = v.t + 4'd1;
      r.u = 4'd0;
    end else begin
      r.t = v.t;
      r.u = v.u + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      EDIT_H:  return SEL_H;
      EDIT_M:  return SEL_M;
      EDIT_S:  return SEL_S;
      default: return SEL_NONE;
    endcase
  endfunction

  state_t      state, state_n;
  bcd2_t       hr, mn, sc, hr_n, mn_n, sc_n;
  logic [23:0] idle, idle_n;
  logic [3:0]  pcnt, pcnt_n;
  logic        mode_evt, inc_evt;
  logic        set_q;
  logic [1:0]  sel_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .CLOCK (CLOCK),
    .rst   (rst),
    .btn   (btn_mode),
    .press (mode_evt)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .CLOCK (CLOCK),
    .rst   (rst),
    .btn   (btn_inc),
    .press (inc_evt)
  );

  always_comb begin
    state_n = state;
    hr_n    = hr;
    mn_n    = mn;
    sc_n    = sc;
    idle_n  = '0;
    pcnt_n  = '0;
    case (state)
      RUN: begin
        if (mode_evt) begin
          hr_n    = {H1, H0};
          mn_n    = {M1, M0};
          sc_n    = {S1, S0};
          state_n = EDIT_H;
        end
      end
      EDIT_H, EDIT_M, EDIT_S: begin
        // Mode has priority; a simultaneous inc is dropped.
        if (mode_evt) begin
          state_n = (state == EDIT_H) ? EDIT_M :
                    (state == EDIT_M) ? EDIT_S : SETUP;
        end else if (inc_evt) begin
          case (state)
            EDIT_H:  hr_n = inc_field(hr, 1'b1);
            EDIT_M:  mn_n = inc_field(mn, 1'b0);
            default: sc_n = inc_field(sc, 1'b0);
          endcase
        end else if (idle == TIMEOUT - 24'd1) begin
          state_n = RUN;
        end else begin
          idle_n = idle + 24'd1;
        end
      end
      SETUP: state_n = PULSE;
      PULSE: begin
        if (pcnt == SET_PULSE - 4'd1) state_n = RUN;
        else                          pcnt_n  = pcnt + 4'd1;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state <= RUN;
      hr    <= '0;
      mn    <= '0;
      sc    <= '0;
      idle  <= '0;
      pcnt  <= '0;
      set_q <= 1'b0;
      sel_q <= SEL_NONE;
    end else begin
      state <= state_n;
      hr    <= hr_n;
      mn    <= mn_n;
      sc    <= sc_n;
      idle  <= idle_n;
      pcnt  <= pcnt_n;
      set_q <= (state_n == PULSE);
      sel_q <= sel_of(state_n);
    end
  end

  assign H1_ld    = hr.t;
  assign H0_ld    = hr.u;
  assign M1_ld    = mn.t;
  assign M0_ld    = mn.u;
  assign S1_ld    = sc.t;
  assign S0_ld    = sc.u;
  assign set_s    = set_q;
  assign set_m    = set_q;
  assign set_h    = set_q;
  assign edit_sel = sel_q;

endmodule
